wbu_reword: RTL and testbench

Receive-side word assembler for the hex-bits bus protocol. It consumes the 7-bit `{newline, 6-bit}` character stream produced by the line decoder. From the first character of each word it recovers the word's length, then packs 1–6 characters MSB-first into one 36-bit compressed command word. It sits between the character decoder and the decompressor, and is the exact inverse of the transmit-side 36-bit-to-6-bit word splitter.

---
 rtl/wbu_reword.sv | 122 ++++++++++++
 tb/tb_wbu_reword.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/wbu_reword.sv
// Receive-side word assembler: packs 1-6 hex-bits characters, MSB-first, into one
// 36-bit compressed command word. The length of each word comes from its first character.
module wbu_reword #(
  parameter bit OPT_NL_ABORT = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_stb,
  input  logic [6:0]  i_byte,
  output logic        o_stb,
  output logic [35:0] o_word,
  output logic        o_err,
  output logic        o_active
);

  // Handshake: i_stb qualifies i_byte and is always accepted. There is no ready signal.
  // o_stb and o_err are single-cycle pulses with no backpressure, and they are never high together.

  typedef enum logic { IDLE = 1'b0, ASSEMBLE = 1'b1 } state_t;

  state_t      state, nx_state;
  logic [2:0]  r_remaining, nx_remaining;
  logic [2:0]  r_slot, nx_slot;
  logic [35:0] r_word, nx_word, word_ins, nx_out;
  logic        nx_stb, nx_err;
  logic [5:0]  c;
  logic        nl;
  logic [2:0]  first_len;

  assign c  = i_byte[5:0];
  assign nl = i_byte[6];

  function automatic logic [2:0] word_len(input logic [5:0] ch);
    if (ch[5:3] == 3'b000)       return 3'd1;
    else if (ch[5:2] == 4'b0010) return 3'd6;
    else if (ch[5:2] == 4'b0011) return 3'd2 + {1'b0, ch[1:0]};
    else if (ch[5:4] == 2'b01)   return 3'd2;
    else if (ch[5:4] == 2'b10)   return 3'd1;
    else                         return 3'd6;
  endfunction

  assign first_len = word_len(c);

  // Slot k occupies bits [35-6k : 30-6k]. Slot 0 is only ever written from IDLE.
  always_comb begin
    word_ins = r_word;
    case (r_slot)
      3'd0:    word_ins[35:30] = c;
      3'd1:    word_ins[29:24] = c;
      3'd2:    word_ins[23:18] = c;
      3'd3:    word_ins[17:12] = c;
      3'd4:    word_ins[11:6]  = c;
      default: word_ins[5:0]   = c;
    endcase
  end

  always_comb begin
    nx_state     = state;
    nx_remaining = r_remaining;
    nx_slot      = r_slot;
    nx_word      = r_word;
    nx_out       = o_word;
    nx_stb       = 1'b0;
    nx_err       = 1'b0;
    case (state)
      IDLE: begin
        if (i_stb && !nl) begin
          nx_word = {c, 30'h0};
          if (first_len == 3'd1) begin
            nx_stb = 1'b1;
            nx_out = {c, 30'h0};
          end else begin
            nx_remaining = first_len - 3'd1;
            nx_slot      = 3'd1;
            nx_state     = ASSEMBLE;
          end
        end
      end
      ASSEMBLE: begin
        if (i_stb && !nl) begin
          nx_word      = word_ins;
          nx_slot      = r_slot + 3'd1;
          nx_remaining = r_remaining - 3'd1;
          if (r_remaining == 3'd1) begin
            nx_stb   = 1'b1;
            nx_out   = word_ins;
            nx_state = IDLE;
          end
        end else if (i_stb && nl && OPT_NL_ABORT) begin
          nx_remaining = 3'd0;
          nx_slot      = 3'd0;
          nx_err       = 1'b1;
          nx_state     = IDLE;
        end
      end
      default: nx_state = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state       <= IDLE;
      r_remaining <= 3'd0;
      r_slot      <= 3'd0;
      r_word      <= 36'h0;
      o_word      <= 36'h0;
      o_stb       <= 1'b0;
      o_err       <= 1'b0;
    end else begin
      state       <= nx_state;
      r_remaining <= nx_remaining;
      r_slot      <= nx_slot;
      r_word      <= nx_word;
      o_word      <= nx_out;
      o_stb       <= nx_stb;
      o_err       <= nx_err;
    end
  end

  assign o_active = (r_remaining != 3'd0);

endmodule

// File: tb/tb_wbu_reword.sv
// Directed bench for wbu_reword. It covers the abort and ignore newline options,
// gapped and back-to-back words, and a reset that arrives mid-word.
module tb_wbu_reword;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_stb = 1'b0;
  logic [6:0]  i_byte = 7'h0;
  logic        o_stb, o_err, o_active;
  logic [35:0] o_word;

  logic        i_stb0 = 1'b0;
  logic [6:0]  i_byte0 = 7'h0;
  logic        o_stb0, o_err0, o_active0;
  logic [35:0] o_word0;

  int n_vec = 0;
  int n_err = 0;

  always #5 i_clk = ~i_clk;

  wbu_reword #(.OPT_NL_ABORT(1'b1)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_stb(i_stb), .i_byte(i_byte),
    .o_stb(o_stb), .o_word(o_word), .o_err(o_err), .o_active(o_active)
  );

  wbu_reword #(.OPT_NL_ABORT(1'b0)) dut0 (
    .i_clk(i_clk), .i_reset(i_reset), .i_stb(i_stb0), .i_byte(i_byte0),
    .o_stb(o_stb0), .o_word(o_word0), .o_err(o_err0), .o_active(o_active0)
  );

  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one input beat to the abort-mode instance and sample #1 after the edge that consumes it.
  task automatic tick(input logic stb, input logic [6:0] b);
    i_stb = stb;
    i_byte = b;
    @(posedge i_clk);
    #1;
    i_stb = 1'b0;
  endtask

  task automatic tick0(input logic stb, input logic [6:0] b);
    i_stb0 = stb;
    i_byte0 = b;
    @(posedge i_clk);
    #1;
    i_stb0 = 1'b0;
  endtask

  logic [6:0] six [6] = '{7'h08, 7'h01, 7'h02, 7'h03, 7'h04, 7'h05};

  initial begin
    // reset state
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_stb", {35'h0, o_stb}, 36'h0);
    chk("rst_err", {35'h0, o_err}, 36'h0);
    chk("rst_active", {35'h0, o_active}, 36'h0);
    chk("rst_word", o_word, 36'h0);
    i_reset = 1'b0;
    tick(1'b0, 7'h00);

    // single character
    tick(1'b1, 7'h05);
    chk("single_stb", {35'h0, o_stb}, 36'h1);
    chk("single_word", o_word, 36'h1_4000_0000);
    chk("single_active", {35'h0, o_active}, 36'h0);
    tick(1'b0, 7'h00);
    chk("single_stb_drop", {35'h0, o_stb}, 36'h0);
    chk("single_word_hold", o_word, 36'h1_4000_0000);

    // six characters back to back
    for (int i = 0; i < 6; i++) begin
      tick(1'b1, six[i]);
      if (i < 5) begin
        chk($sformatf("six_active_%0d", i), {35'h0, o_active}, 36'h1);
        chk($sformatf("six_nostb_%0d", i), {35'h0, o_stb}, 36'h0);
      end
    end
    chk("six_stb", {35'h0, o_stb}, 36'h1);
    chk("six_word", o_word, 36'h2_0108_3105);
    chk("six_active_end", {35'h0, o_active}, 36'h0);

    // four characters with 3-cycle gaps
    tick(1'b1, 7'h0E);
    for (int k = 0; k < 3; k++) begin
      repeat (3) begin
        tick(1'b0, 7'h00);
        chk("gap_nostb", {35'h0, o_stb}, 36'h0);
      end
      tick(1'b1, 7'h3F);
      if (k < 2) chk("gap_nostb_char", {35'h0, o_stb}, 36'h0);
    end
    chk("gap_stb", {35'h0, o_stb}, 36'h1);
    chk("gap_word", o_word, 36'h3_BFFF_F000);

    // newline while idle is ignored silently
    tick(1'b1, 7'h40);
    chk("idle_nl_err", {35'h0, o_err}, 36'h0);
    chk("idle_nl_active", {35'h0, o_active}, 36'h0);

    // abort and recover
    tick(1'b1, 7'h30);
    tick(1'b1, 7'h11);
    tick(1'b1, 7'h22);
    tick(1'b1, 7'h40);
    chk("abort_err", {35'h0, o_err}, 36'h1);
    chk("abort_nostb", {35'h0, o_stb}, 36'h0);
    chk("abort_active", {35'h0, o_active}, 36'h0);
    chk("abort_word_hold", o_word, 36'h3_BFFF_F000);
    tick(1'b1, 7'h05);
    chk("abort_err_drop", {35'h0, o_err}, 36'h0);
    chk("recover_stb", {35'h0, o_stb}, 36'h1);
    chk("recover_word", o_word, 36'h1_4000_0000);

    // newline ignored when abort is disabled
    tick0(1'b1, 7'h30);
    tick0(1'b1, 7'h11);
    tick0(1'b1, 7'h22);
    tick0(1'b1, 7'h40);
    chk("noabort_err", {35'h0, o_err0}, 36'h0);
    chk("noabort_active", {35'h0, o_active0}, 36'h1);
    tick0(1'b1, 7'h33);
    tick0(1'b1, 7'h01);
    chk("noabort_nostb", {35'h0, o_stb0}, 36'h0);
    tick0(1'b1, 7'h02);
    chk("noabort_stb", {35'h0, o_stb0}, 36'h1);
    chk("noabort_word", o_word0, 36'hC_118B_3042);

    // back-to-back words
    tick(1'b1, 7'h05);
    chk("b2b_stb0", {35'h0, o_stb}, 36'h1);
    chk("b2b_word0", o_word, 36'h1_4000_0000);
    tick(1'b1, 7'h1A);
    chk("b2b_gap", {35'h0, o_stb}, 36'h0);
    chk("b2b_active", {35'h0, o_active}, 36'h1);
    tick(1'b1, 7'h2B);
    chk("b2b_stb1", {35'h0, o_stb}, 36'h1);
    chk("b2b_word1", o_word, 36'h6_AB00_0000);
    tick(1'b1, 7'h05);
    chk("b2b_stb2", {35'h0, o_stb}, 36'h1);
    chk("b2b_word2", o_word, 36'h1_4000_0000);

    // reset mid-word
    tick(1'b1, 7'h08);
    tick(1'b1, 7'h01);
    tick(1'b1, 7'h02);
    #2;
    i_reset = 1'b1;
    #1;
    chk("mrst_word", o_word, 36'h0);
    chk("mrst_active", {35'h0, o_active}, 36'h0);
    chk("mrst_stb", {35'h0, o_stb}, 36'h0);
    chk("mrst_err", {35'h0, o_err}, 36'h0);
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    tick(1'b0, 7'h00);
    chk("mrst_quiet_stb", {35'h0, o_stb}, 36'h0);
    chk("mrst_quiet_err", {35'h0, o_err}, 36'h0);
    tick(1'b1, 7'h05);
    chk("mrst_stb_after", {35'h0, o_stb}, 36'h1);
    chk("mrst_word_after", o_word, 36'h1_4000_0000);
    tick(1'b0, 7'h00);
    chk("mrst_single_pulse", {35'h0, o_stb}, 36'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
